// File: rtl/rx_deframer_pkg.sv
// Shared types and constants for the HDLC receive deframer and its CRC unit.
package rx_deframer_pkg;

  typedef enum logic [2:0] {
    HUNT     = 3'b001,
    SYNC     = 3'b010,
    IN_FRAME = 3'b100
  } state_t;

  localparam logic [7:0]  FLAG             = 8'h7E;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE      = 16'h1D0F;
  localparam logic [15:0] CRC_POLY         = 16'h1021;
  localparam int          MIN_FRAME_OCTETS = 3;
  localparam int          OCTET_CNT_W      = $clog2(MIN_FRAME_OCTETS + 1);

  function automatic logic [5:0] count_ones8(input logic [7:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Length of the run of ones inside a flag; one fewer forces a stuffed zero.
  localparam logic [5:0] FLAG_ONES = count_ones8(FLAG);

  function automatic logic crc_good(input logic [15:0] value);
    return value == CRC_RESIDUE;
  endfunction

endpackage

// File: rtl/rx_deframer_crc.sv
// Bit-serial CRC-16 (poly 0x1021) shifting toward the MSB; clear wins over enable.
module crc16_serial
  import rx_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;
  logic        feedback;

  assign feedback    = bit_in ^ crc_reg[15];
  assign crc_next[0] = feedback & CRC_POLY[0];

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_bit
      assign crc_next[gi] = crc_reg[gi-1] ^ (feedback & CRC_POLY[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clear) begin
      crc_reg <= CRC_INIT;
    end else if (enable) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag sync, zero destuffing, 2-octet FCS holdback.
// Optional FCS checking is compiled in with macro RX_DEFRAMER_FCS_CHECK_EN.
module rx_deframer
  import rx_deframer_pkg::*;
(
  input  logic       netclk,
  input  logic       reset,
  input  logic       rxdata,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sof,
  output logic       eop,
  output logic       frame_ok,
  output logic       abort,
  output logic       in_sync
);

  state_t                 state_reg, state_next;
  logic [5:0]             ones_reg, ones_next;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic [OCTET_CNT_W-1:0] octet_cnt_reg, octet_cnt_next;
  logic [6:0]             shift_reg, shift_next;
  logic [7:0]             hold0_reg, hold0_next;
  logic [7:0]             hold1_reg, hold1_next;
  logic [1:0]             held_reg, held_next;
  logic                   first_reg, first_next;
  logic [7:0]             data_out_reg, data_out_next;
  logic                   dv_reg, dv_next;
  logic                   sof_reg, sof_next;
  logic                   eop_reg, eop_next;
  logic                   ok_reg, ok_next;
  logic                   abort_reg, abort_next;
  logic                   in_sync_reg;

  logic       is_flag, is_abort, data_bit, octet_done;
  logic       aligned, long_enough, crc_ok;
  logic [7:0] octet;

  assign is_flag     = ~rxdata && (ones_reg == FLAG_ONES);
  assign is_abort    = rxdata && (ones_reg == FLAG_ONES);
  assign data_bit    = (ones_reg < FLAG_ONES - 6'd1) && (state_reg != HUNT);
  assign octet_done  = data_bit && (bit_cnt_reg == 3'd7);
  assign octet       = {rxdata, shift_reg};
  // The flag's leading 0 and first five 1s pass as data bits before it is recognised,
  // so an aligned closing flag leaves the bit counter at FLAG_ONES, not 0.
  assign aligned     = (bit_cnt_reg == 3'(FLAG_ONES));
  assign long_enough = (octet_cnt_reg == OCTET_CNT_W'(MIN_FRAME_OCTETS));

`ifdef RX_DEFRAMER_FCS_CHECK_EN
  logic [15:0] crc_value;
  logic [15:0] crc_snap_reg;
  logic        snap_pending_reg;

  crc16_serial u_crc (
    .clk    (netclk),
    .clear  (reset | is_flag | is_abort),
    .enable (data_bit),
    .bit_in (rxdata),
    .crc    (crc_value)
  );

  // Capture the CRC at each octet boundary so the flag-prefix bits are excluded.
  always_ff @(posedge netclk) begin
    if (reset) begin
      snap_pending_reg <= 1'b0;
      crc_snap_reg     <= CRC_INIT;
    end else begin
      snap_pending_reg <= octet_done;
      if (snap_pending_reg) crc_snap_reg <= crc_value;
    end
  end

  assign crc_ok = crc_good(crc_snap_reg);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    ones_next      = rxdata ? ((&ones_reg) ? ones_reg : ones_reg + 6'd1) : 6'd0;
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    octet_cnt_next = octet_cnt_reg;
    shift_next     = shift_reg;
    hold0_next     = hold0_reg;
    hold1_next     = hold1_reg;
    held_next      = held_reg;
    first_next     = first_reg;
    data_out_next  = data_out_reg;
    dv_next        = 1'b0;
    sof_next       = 1'b0;
    eop_next       = 1'b0;
    ok_next        = 1'b0;
    abort_next     = 1'b0;

    if (is_abort) begin
      abort_next     = (state_reg == IN_FRAME);
      state_next     = HUNT;
      bit_cnt_next   = '0;
      octet_cnt_next = '0;
      held_next      = '0;
      first_next     = 1'b0;
    end else if (is_flag) begin
      eop_next       = (state_reg == IN_FRAME);
      ok_next        = (state_reg == IN_FRAME) && aligned && long_enough && crc_ok;
      state_next     = SYNC;
      bit_cnt_next   = '0;
      octet_cnt_next = '0;
      held_next      = '0;
      first_next     = 1'b1;
    end else if (data_bit) begin
      shift_next   = octet[7:1];
      bit_cnt_next = bit_cnt_reg + 3'd1;
      if (octet_done) begin
        if (state_reg == SYNC) state_next = IN_FRAME;
        if (!long_enough) octet_cnt_next = octet_cnt_reg + OCTET_CNT_W'(1);
        case (held_reg)
          2'd0: begin
            hold0_next = octet;
            held_next  = 2'd1;
          end
          2'd1: begin
            hold1_next = octet;
            held_next  = 2'd2;
          end
          default: begin
            dv_next       = 1'b1;
            sof_next      = first_reg;
            first_next    = 1'b0;
            data_out_next = hold0_reg;
            hold0_next    = hold1_reg;
            hold1_next    = octet;
          end
        endcase
      end
    end
  end

  always_ff @(posedge netclk) begin
    if (reset) begin
      state_reg     <= HUNT;
      ones_reg      <= '0;
      bit_cnt_reg   <= '0;
      octet_cnt_reg <= '0;
      shift_reg     <= '0;
      hold0_reg     <= '0;
      hold1_reg     <= '0;
      held_reg      <= '0;
      first_reg     <= 1'b0;
      data_out_reg  <= 8'h00;
      dv_reg        <= 1'b0;
      sof_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      ok_reg        <= 1'b0;
      abort_reg     <= 1'b0;
      in_sync_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ones_reg      <= ones_next;
      bit_cnt_reg   <= bit_cnt_next;
      octet_cnt_reg <= octet_cnt_next;
      shift_reg     <= shift_next;
      hold0_reg     <= hold0_next;
      hold1_reg     <= hold1_next;
      held_reg      <= held_next;
      first_reg     <= first_next;
      data_out_reg  <= data_out_next;
      dv_reg        <= dv_next;
      sof_reg       <= sof_next;
      eop_reg       <= eop_next;
      ok_reg        <= ok_next;
      abort_reg     <= abort_next;
      in_sync_reg   <= (state_reg != HUNT);
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = dv_reg;
  assign sof        = sof_reg;
  assign eop        = eop_reg;
  assign frame_ok   = ok_reg;
  assign abort      = abort_reg;
  assign in_sync    = in_sync_reg;

endmodule

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 The block SHALL have a single clock `netclk`, and all state SHALL update on its rising edge.
REQ-002 The reset `reset` SHALL be synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- `netclk`  in  1  line bit clock; one line bit sampled per cycle.
- `reset`  in  1  synchronous, active-high reset.
- `rxdata`  in  1  serial HDLC line bit.
- `data_out`  out  8  received payload octet.
- `data_valid`  out  1  one-cycle strobe qualifying `data_out`.
- `sof`  out  1  high with `data_valid` on the first payload octet of a frame.
- `eop`  out  1  one-cycle strobe at closing-flag recognition.
- `frame_ok`  out  1  frame status; valid only while `eop` is high.
- `abort`  out  1  one-cycle strobe when an abort is detected mid-frame.
- `in_sync`  out  1  high while flag synchronisation is held.

Function
REQ-004 There SHALL be three states: `HUNT`, `SYNC` (flags seen, no data yet) and `IN_FRAME`.
REQ-005 A 6-bit consecutive-ones counter SHALL run over the raw bit stream:
- 0 received after exactly five 1s: stuffed zero, deleted; it feeds neither the octet assembly nor the CRC.
- 0 received after exactly six 1s: flag.
- Seventh consecutive 1: abort.
REQ-006 Transitions SHALL be:
- `HUNT`→`SYNC` on a flag.
- `SYNC`→`SYNC` on a flag.
- `SYNC`→`IN_FRAME` on the first completed non-flag octet.
- `IN_FRAME`→`SYNC` on a flag.
- Any state→`HUNT` on an abort.
REQ-007 Octets SHALL be assembled LSB first from destuffed bits.
REQ-008 The 7 leading flag bits (0 followed by six 1s) SHALL NOT be delivered as data.
REQ-009 The last two octets before the closing flag are FCS and SHALL NOT be output. A 2-octet holdback buffer SHALL be used: octet N is emitted only once octet N+2 is complete.
REQ-010 `data_valid` for octet N SHALL assert in the cycle after the edge that samples the final bit of octet N+2.
REQ-011 `sof` SHALL be high only on the first `data_valid` of each frame.
REQ-012 `eop` SHALL assert in the cycle after the edge that samples the closing flag's final 0.
REQ-013 `eop` SHALL NOT coincide with `data_valid`.
REQ-014 `frame_ok`=1 SHALL require all three conditions:
- The closing flag is octet-aligned (destuffed bit count before the flag is a multiple of 8).
- At least 3 octets (≥1 payload + 2 FCS) were received.
- The CRC check passes.
REQ-015 Back-to-back flags (0 octets between them) SHALL produce no `eop`.
REQ-016 A closing flag SHALL also serve as the opening flag of the next frame.
REQ-017 A frame of 1–2 octets SHALL produce `eop` with `frame_ok`=0 and no `data_valid`.
REQ-018 The CRC SHALL be CRC-16, polynomial 0x1021:
- 16-bit register, initialised to 0xFFFF at frame start.
- Per destuffed bit b: feedback = b XOR crc[15]; shift toward the MSB; XOR feedback into bits 0, 5 and 12.
- Computed over payload and FCS.
- A good frame SHALL leave residue 0x1D0F.
REQ-019 On abort in `IN_FRAME`, `abort` SHALL pulse for one cycle, no `eop` SHALL follow, held octets SHALL be discarded, and the state SHALL become `HUNT`.
REQ-020 An abort in `HUNT` or `SYNC` SHALL give no `abort` pulse.
REQ-021 `in_sync` SHALL be 0 in `HUNT` and 1 otherwise.

Reset
REQ-022 On `reset`, the block SHALL go to `HUNT`, clear the ones counter, bit counter, octet count and holdback buffer, and set the CRC register to 0xFFFF.
REQ-023 On `reset`, `data_out`=0x00 and `data_valid`, `sof`, `eop`, `frame_ok`, `abort`, `in_sync` SHALL all be 0.
REQ-024 Reset mid-frame SHALL discard the frame silently: no `eop`, no `abort`.

Configuration
REQ-025 With macro `RX_DEFRAMER_FCS_CHECK_EN` defined, the CRC check SHALL be compiled in as in REQ-014 and REQ-018.
REQ-026 With `RX_DEFRAMER_FCS_CHECK_EN` undefined, the CRC logic SHALL be absent: FCS octets are still stripped, and `frame_ok` reflects only the alignment and length rules.

Structure
REQ-027 A shared package SHALL hold:
- the state encoding (one-hot, 3 bits);
- `FLAG` = 8'h7E;
- `CRC_INIT` = 16'hFFFF;
- `CRC_RESIDUE` = 16'h1D0F;
- `MIN_FRAME_OCTETS` = 3.
REQ-028 The bit-serial CRC SHALL be a single sub-module, `crc16_serial` (inputs: clock, clear, enable, bit; output: 16-bit CRC register).

Verification
REQ-029 Idle all-1s, then 7E 7E: `in_sync` goes 1 on the second edge after the final 0; no other outputs.
REQ-030 Flag; payload 01 02 03 with FCS from the bench transmitter model; flag: three `data_valid` pulses 01 (with `sof`), 02, 03, then `eop`=1 with `frame_ok`=1.
REQ-031 Payload 1F F8, needing stuffed zeros: octets 1F, F8 delivered intact; `frame_ok`=1.
REQ-032 Same frame with one payload bit flipped: same `data_valid` count; `eop` with `frame_ok`=0. With the macro undefined: `frame_ok`=1.
REQ-033 Frame truncated by 7 consecutive 1s after octet 4: one `abort` pulse, no `eop`, `in_sync`=0; the next flagged frame is received correctly.
REQ-034 Three cases, each checked separately:
- Flag, 2 octets, flag: `eop` with `frame_ok`=0 and no `data_valid`.
- Flag, 3 octets + 3 bits, flag: `frame_ok`=0.
- Reset mid-frame: no `eop`.
